// File: rtl/io_stream_port.sv
// Word-stream I/O device for non-frame LOAD/STORE syscalls.
// Host input goes through an RX FIFO and CPU output through a TX FIFO.
module io_stream_port #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          io_read,
  input  logic          io_write,
  input  logic          selframe,
  input  logic [15:0]   io_wdata,
  output logic [15:0]   io_rdata,
  output logic          ioack,
  input  logic [15:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [15:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   in_level,
  output logic [AW:0]   out_level
);

  typedef enum logic [0:0] {StIdle, StAck} state_e;

  localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

  state_e        state_q;
  logic [15:0]   rx_mem [DEPTH];
  logic [15:0]   tx_mem [DEPTH];
  logic [AW-1:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
  logic [AW:0]   rx_level_q, tx_level_q;
  logic          rd_req, wr_req, rx_push, rx_pop, tx_push, tx_pop;

  always_comb begin
    rd_req    = io_read & ~selframe;
    wr_req    = io_write & ~selframe & ~io_read;
    in_ready  = (rx_level_q != Full);
    out_valid = (tx_level_q != '0);
    out_data  = tx_mem[tx_rd_q];
    in_level  = rx_level_q;
    out_level = tx_level_q;
    rx_push   = in_valid & in_ready;
    tx_pop    = out_valid & out_ready;
    // Only IDLE issues a pop/push, so a held strobe moves exactly one word.
    rx_pop    = (state_q == StIdle) & rd_req & (rx_level_q != '0);
    tx_push   = (state_q == StIdle) & wr_req & (tx_level_q != Full);
  end

  // Storage is not reset; pointers and levels define what is valid.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_q] <= in_data;
    if (tx_push) tx_mem[tx_wr_q] <= io_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_level_q <= '0;
      tx_level_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
      if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
      if (rx_push && !rx_pop)      rx_level_q <= rx_level_q + (AW + 1)'(1);
      else if (!rx_push && rx_pop) rx_level_q <= rx_level_q - (AW + 1)'(1);
      if (tx_push && !tx_pop)      tx_level_q <= tx_level_q + (AW + 1)'(1);
      else if (!tx_push && tx_pop) tx_level_q <= tx_level_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      ioack    <= 1'b0;
      io_rdata <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rx_pop) begin
            io_rdata <= rx_mem[rx_rd_q];
            ioack    <= 1'b1;
            state_q  <= StAck;
          end else if (tx_push) begin
            ioack    <= 1'b1;
            state_q  <= StAck;
          end
        end
        StAck: begin
          if (!io_read && !io_write) begin
            ioack   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_io_stream_port.sv
// Directed self-checking bench for io_stream_port.
module tb_io_stream_port;

  logic        clock, reset;
  logic        io_read, io_write, selframe;
  logic [15:0] io_wdata, io_rdata, in_data, out_data;
  logic        ioack, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_level, out_level;

  int checks = 0;
  int failures = 0;

  io_stream_port #(.DEPTH(8), .AW(3)) dut (
    .clock(clock), .reset(reset), .io_read(io_read), .io_write(io_write),
    .selframe(selframe), .io_wdata(io_wdata), .io_rdata(io_rdata), .ioack(ioack),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_level(in_level), .out_level(out_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_push(input logic [15:0] d);
    in_data = d; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; io_read = 0; io_write = 0; selframe = 0; io_wdata = '0;
    in_data = '0; in_valid = 0; out_ready = 0;
    step(); step();
    check("rst_ioack", ioack, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_levels", {in_level, out_level}, 0);
    reset = 1'b1;
    step();

    // T2 load
    host_push(16'h1234);
    host_push(16'hBEEF);
    check("t2_level2", in_level, 2);
    io_read = 1;
    step();
    check("t2_ack1", ioack, 1);
    check("t2_rdata1", io_rdata, 16'h1234);
    check("t2_level1", in_level, 1);
    step(); step(); step();
    check("t2_hold_ack", ioack, 1);
    check("t2_hold_rdata", io_rdata, 16'h1234);
    check("t2_single_pop", in_level, 1);
    io_read = 0;
    step();
    check("t2_ack_drop", ioack, 0);
    io_read = 1;
    step();
    check("t2_ack2", ioack, 1);
    check("t2_rdata2", io_rdata, 16'hBEEF);
    check("t2_level0", in_level, 0);
    io_read = 0;
    step();

    // T3 empty stall
    io_read = 1;
    for (int i = 0; i < 5; i++) step();
    check("t3_stall", ioack, 0);
    host_push(16'h00A5);
    check("t3_no_ack_at_push", ioack, 0);
    step();
    check("t3_ack", ioack, 1);
    check("t3_rdata", io_rdata, 16'h00A5);
    check("t3_level", in_level, 0);
    io_read = 0;
    step();

    // T1 reset mid-ACK with RX level 3
    for (int i = 0; i < 4; i++) host_push(16'h0011 * 16'(i + 1));
    io_read = 1;
    step();
    check("t1_pre_ack", ioack, 1);
    check("t1_pre_level", in_level, 3);
    reset = 1'b0;
    #1;
    check("t1_ioack", ioack, 0);
    check("t1_rdata", io_rdata, 0);
    check("t1_in_level", in_level, 0);
    check("t1_out_valid", out_valid, 0);
    check("t1_in_ready", in_ready, 1);
    io_read = 0;
    step();
    reset = 1'b1;
    step();

    // T4 store / full
    out_ready = 0;
    for (int i = 1; i <= 8; i++) begin
      io_wdata = 16'(i); io_write = 1;
      step();
      check("t4_store_ack", ioack, 1);
      io_write = 0;
      step();
    end
    check("t4_full_level", out_level, 8);
    check("t4_head", out_data, 1);
    io_wdata = 16'h0009; io_write = 1;
    step(); step();
    check("t4_full_stall", ioack, 0);
    out_ready = 1;
    step();
    out_ready = 0;
    check("t4_after_pop_level", out_level, 7);
    check("t4_after_pop_head", out_data, 2);
    step();
    check("t4_ninth_ack", ioack, 1);
    check("t4_ninth_level", out_level, 8);
    io_write = 0;
    step();
    out_ready = 1;
    for (int i = 2; i <= 9; i++) begin
      check("t4_drain", out_data, 32'(i));
      step();
    end
    out_ready = 0;
    check("t4_empty", out_valid, 0);

    // T5 simultaneous RX push and pop while full
    for (int i = 0; i < 8; i++) host_push(16'h0100 + 16'(i));
    check("t5_rx_full_level", in_level, 8);
    check("t5_rx_full_ready", in_ready, 0);
    in_data = 16'hDEAD; in_valid = 1; io_read = 1;
    step();
    check("t5_rx_level", in_level, 7);
    check("t5_rx_rdata", io_rdata, 16'h0100);
    in_valid = 0; io_read = 0;
    step();
    for (int i = 1; i < 8; i++) begin
      io_read = 1;
      step();
      check("t5_rx_drain", io_rdata, 32'h0100 + 32'(i));
      io_read = 0;
      step();
    end
    check("t5_rx_empty", in_level, 0);

    // TX push and pop in the same cycle
    io_wdata = 16'h0055; io_write = 1;
    step();
    io_write = 0;
    step();
    check("t5_tx_level1", out_level, 1);
    io_wdata = 16'h0066; io_write = 1; out_ready = 1;
    step();
    check("t5_tx_level_same", out_level, 1);
    check("t5_tx_head", out_data, 16'h0066);
    io_write = 0; out_ready = 0;
    step();
    out_ready = 1;
    step();
    out_ready = 0;
    check("t5_tx_empty", out_valid, 0);

    // Pointer wrap: 24 words through both FIFOs
    for (int i = 0; i < 24; i++) begin
      host_push(16'hA000 + 16'(i));
      io_read = 1;
      step();
      check("t5_wrap_rx", io_rdata, 32'hA000 + 32'(i));
      io_read = 0;
      step();
      io_wdata = 16'hC000 + 16'(i); io_write = 1;
      step();
      io_write = 0;
      step();
      check("t5_wrap_tx", out_data, 32'hC000 + 32'(i));
      out_ready = 1;
      step();
      out_ready = 0;
    end
    check("t5_wrap_levels", {in_level, out_level}, 0);

    // T6 selframe requests are ignored
    host_push(16'h0077);
    host_push(16'h0088);
    selframe = 1; io_read = 1;
    step(); step(); step();
    check("t6_ioack", ioack, 0);
    check("t6_in_level", in_level, 2);
    io_read = 0; io_write = 1; io_wdata = 16'h0099;
    step(); step();
    check("t6_wr_ioack", ioack, 0);
    check("t6_out_level", out_level, 0);
    io_write = 0; selframe = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
